// File: rtl/wb_bram_arbiter.sv
// Round-robin arbiter sharing one fixed-latency BRAM between two Wishbone classic masters.
// Define ARB_FIXED_PRIO_EN to replace round-robin with fixed m0-first priority.
module wb_bram_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int BRAM_LAT = 10
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [31:0]       m0_adr_i,
  input  logic [31:0]       m0_dat_i,
  output logic [31:0]       m0_dat_o,
  output logic              m0_ack_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [31:0]       m1_adr_i,
  input  logic [31:0]       m1_dat_i,
  output logic [31:0]       m1_dat_o,
  output logic              m1_ack_o,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic [1:0]        gnt_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt;
  logic              owner;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] adr_q;
  logic [31:0]       dat_q;
  logic [31:0]       rdata;
  logic              req0, req1, win, owner_cyc, ack;
  logic              unused_bits;

  assign req0      = m0_cyc_i & m0_stb_i;
  assign req1      = m1_cyc_i & m1_stb_i;
  assign owner_cyc = owner ? m1_cyc_i : m0_cyc_i;

  // Only the word-address window of each byte address reaches the BRAM.
  assign unused_bits = ^{m0_adr_i[31:ADDR_W+2], m0_adr_i[1:0],
                         m1_adr_i[31:ADDR_W+2], m1_adr_i[1:0]};

`ifdef ARB_FIXED_PRIO_EN
  assign win = ~req0;
`else
  logic rr;
  assign win = (req0 & req1) ? rr : req1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req0 | req1) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      // An owner that dropped cyc gets no ack; skip straight back to IDLE.
      WAIT:  if (cnt == 8'd0) state_nxt = owner_cyc ? ACK : IDLE;
      ACK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bram_en    = 1'b0;
    bram_we    = 4'h0;
    bram_addr  = '0;
    bram_wdata = 32'h0;
    gnt_o      = 2'b00;
    ack        = 1'b0;
    if (state == ISSUE) begin
      bram_en    = 1'b1;
      bram_we    = we_q ? sel_q : 4'h0;
      bram_addr  = adr_q;
      bram_wdata = dat_q;
    end
    if (state != IDLE) gnt_o = owner ? 2'b10 : 2'b01;
    if (state == ACK)  ack = owner_cyc;
  end

  assign m0_ack_o = ack & ~owner;
  assign m1_ack_o = ack & owner;
  assign m0_dat_o = m0_ack_o ? rdata : 32'h0;
  assign m1_dat_o = m1_ack_o ? rdata : 32'h0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt   <= 8'd0;
      owner <= 1'b0;
      we_q  <= 1'b0;
      sel_q <= 4'h0;
      adr_q <= '0;
      dat_q <= 32'h0;
      rdata <= 32'h0;
`ifndef ARB_FIXED_PRIO_EN
      rr    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req0 | req1) begin
          owner <= win;
          we_q  <= win ? m1_we_i  : m0_we_i;
          sel_q <= win ? m1_sel_i : m0_sel_i;
          adr_q <= win ? m1_adr_i[ADDR_W+1:2] : m0_adr_i[ADDR_W+1:2];
          dat_q <= win ? m1_dat_i : m0_dat_i;
`ifndef ARB_FIXED_PRIO_EN
          // Loser of a contested grant is preferred at the next arbitration.
          if (req0 & req1) rr <= ~win;
`endif
        end
        ISSUE: cnt <= 8'(BRAM_LAT - 1);
        WAIT: begin
          if (cnt == 8'd0) rdata <= bram_rdata;
          else             cnt   <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Directed bench for wb_bram_arbiter with a behavioural fixed-latency BRAM.
module tb_wb_bram_arbiter;
  localparam int LAT = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  cyc = 2'b00, stb = 2'b00, wen = 2'b00, ack;
  logic [3:0]  sel  [2];
  logic [31:0] adr  [2];
  logic [31:0] wdat [2];
  logic [31:0] rdat [2];
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wdata, bram_rdata;
  logic [1:0]  gnt;
  logic [31:0] mem  [1024];
  logic [31:0] pipe [LAT];
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  wb_bram_arbiter #(.ADDR_W(10), .BRAM_LAT(LAT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(wen[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(rdat[0]), .m0_ack_o(ack[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(wen[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(rdat[1]), .m1_ack_o(ack[1]),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .gnt_o(gnt)
  );

  // BRAM: data read at en appears LAT cycles later.
  assign bram_rdata = pipe[LAT-1];
  always @(posedge clk) begin
    pipe[0] <= bram_en ? mem[bram_addr] : 32'h0;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    if (bram_en)
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transfer from port p; request presented in an IDLE cycle, ack expected 12 cycles later.
  task automatic xfer(input int p, input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_rd, input string tag);
    bit done = 0;
    @(negedge clk);
    cyc[p] = 1; stb[p] = 1; wen[p] = w; sel[p] = s; adr[p] = a; wdat[p] = d;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, "_en"}, bram_en, 1'b1);
        chk({tag, "_addr"}, bram_addr, a[11:2]);
        chk({tag, "_we"}, bram_we, w ? s : 4'h0);
        chk({tag, "_wdata"}, bram_wdata, d);
        chk({tag, "_gnt"}, gnt, (p == 1) ? 2'b10 : 2'b01);
      end
      if (k == 2) begin
        chk({tag, "_en_once"}, bram_en, 1'b0);
        adr[p] = ~a; wdat[p] = ~d;
      end
      if (ack[p]) begin
        chk({tag, "_lat"}, k, 12);
        if (!w) chk({tag, "_rdata"}, rdat[p], exp_rd);
        chk({tag, "_other_ack"}, ack[1-p], 1'b0);
        chk({tag, "_other_dat"}, rdat[1-p], 32'h0);
        cyc[p] = 0; stb[p] = 0;
        done = 1;
      end
    end
    if (!done) begin
      chk({tag, "_timeout"}, 1'b0, 1'b1);
      cyc[p] = 0; stb[p] = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    bit bad;
    for (int i = 0; i < 2; i++) begin sel[i] = 0; adr[i] = 0; wdat[i] = 0; end

    // Reset, then idle for 100 cycles with everything quiet.
    repeat (3) @(negedge clk);
    rst = 0;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ({rdat[0], rdat[1], ack, bram_en, bram_we, bram_addr, bram_wdata, gnt} !== '0) bad = 1;
    end
    chk("reset_idle", bad, 1'b0);

    // m0 write/read, then an aliased address wrapping onto the same word.
    xfer(0, 1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, 32'h0, "m0_wr");
    xfer(0, 0, 4'hF, 32'h3800_0010, 32'h0, 32'hDEAD_BEEF, "m0_rd");
    xfer(0, 1, 4'hF, 32'h3800_1010, 32'h0BAD_F00D, 32'h0, "m0_wr_wrap");
    xfer(0, 0, 4'hF, 32'h3800_0010, 32'h0, 32'h0BAD_F00D, "m0_rd_wrap");

    // m1 partial-byte write.
    xfer(1, 1, 4'hF, 32'h3800_0020, 32'hFFFF_FFFF, 32'h0, "m1_wr_full");
    xfer(1, 1, 4'h3, 32'h3800_0020, 32'h1234_5678, 32'h0, "m1_wr_part");
    xfer(1, 0, 4'hF, 32'h3800_0020, 32'h0, 32'hFFFF_5678, "m1_rd_part");

    // Both masters hold requests; record grant order.
    @(negedge clk);
    cyc = 2'b11; stb = 2'b11; wen = 2'b00; sel[0] = 4'hF; sel[1] = 4'hF;
    adr[0] = 32'h3800_0010; adr[1] = 32'h3800_0020;
    for (int k = 1; k <= 60 && order.size() < 3; k++) begin
      @(negedge clk);
      if (ack[0]) begin order.push_back(0); chk("arb_m0_dat", rdat[0], 32'h0BAD_F00D); end
      if (ack[1]) begin order.push_back(1); chk("arb_m1_dat", rdat[1], 32'hFFFF_5678); end
    end
    cyc = 2'b00; stb = 2'b00;
    chk("arb_count", order.size(), 3);
    if (order.size() == 3) begin
      chk("arb_first", order[0], 0);
`ifdef ARB_FIXED_PRIO_EN
      chk("arb_second", order[1], 0);
`else
      chk("arb_second", order[1], 1);
`endif
      chk("arb_third", order[2], 0);
    end

    // m0 abandons its read during WAIT while m1 queues up.
    @(negedge clk);
    cyc[0] = 1; stb[0] = 1; wen[0] = 0; adr[0] = 32'h3800_0020;
    bad = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (ack[0]) bad = 1;
      if (k == 3) begin cyc[1] = 1; stb[1] = 1; wen[1] = 0; adr[1] = 32'h3800_0020; end
      if (k == 5) begin cyc[0] = 0; stb[0] = 0; end
      if (k == 12) chk("drop_idle_gnt", gnt, 2'b00);
      if (k == 13) chk("drop_m1_gnt", gnt, 2'b10);
      if (k == 24) begin
        chk("drop_m1_ack", ack[1], 1'b1);
        chk("drop_m1_dat", rdat[1], 32'hFFFF_5678);
      end
    end
    cyc[1] = 0; stb[1] = 0;
    chk("drop_no_m0_ack", bad, 1'b0);

    // Reset pulse during WAIT aborts the transfer.
    @(negedge clk);
    cyc[0] = 1; stb[0] = 1; wen[0] = 1; sel[0] = 4'hF; adr[0] = 32'h3800_0030; wdat[0] = 32'hAAAA_5555;
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_en", bram_en, 1'b0);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_ack", ack, 2'b00);
    rst = 0; cyc[0] = 0; stb[0] = 0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ack !== 2'b00 || gnt !== 2'b00) bad = 1;
    end
    chk("rst_quiet", bad, 1'b0);
    xfer(1, 0, 4'hF, 32'h3800_0010, 32'h0, 32'h0BAD_F00D, "post_rst_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
